instr_mem_loader: RTL
=====================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter WORD_QUANTITY, default 256, giving the number of 32-bit words in instruction memory (1 KiB).
REQ-002 The block SHALL have clk, input, 1, the system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have rst, input, 1, an asynchronous, active-high reset.
REQ-004 The block SHALL have start, input, 1, a single-cycle request to begin a load.
REQ-005 The block SHALL have rx_data, input, 8, the incoming program byte.
REQ-006 The block SHALL have rx_valid, input, 1, asserted by the source when rx_data is valid.
REQ-007 The block SHALL have rx_ready, output, 1, asserted when the loader can accept a byte.
REQ-008 The block SHALL have mem_we, output, 1, the instruction-memory write strobe.
REQ-009 The block SHALL have mem_addr, output, 32, the byte address of the word being written, always word-aligned.
REQ-010 The block SHALL have mem_wdata, output, 32, the instruction word being written.
REQ-011 The block SHALL have cpu_hold, output, 1, which holds the fetch stage (StallF) and pipeline while high.
REQ-012 The block SHALL have done, output, 1, a level signal meaning the load completed successfully.
REQ-013 The block SHALL have error, output, 1, a level signal meaning the header was invalid.
REQ-014 The block SHALL have words_loaded, output, 16, the number of words written so far.

Function
REQ-015 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both high.
REQ-016 Stream format SHALL be: a 16-bit word count N (low byte first), followed by N words of 4 bytes each, little-endian.
REQ-017 State machine SHALL have these states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-018 From IDLE, DONE or ERR, start SHALL move the FSM to LEN_LO, clear done, error and words_loaded, and set cpu_hold.
REQ-019 start SHALL be ignored in LEN_LO, LEN_HI, DATA and WRITE.
REQ-020 rx_ready SHALL be 1 only in LEN_LO, LEN_HI and DATA.
REQ-021 LEN_LO SHALL capture N[7:0] on accept and move to LEN_HI; LEN_HI SHALL capture N[15:8] on accept.
REQ-022 After LEN_HI: N==0 SHALL go to DONE; N>WORD_QUANTITY SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-023 In DATA, the k-th accepted byte (k=0..3) SHALL fill mem_wdata[8k+7:8k]; the 4th accept SHALL move to WRITE.
REQ-024 WRITE SHALL last exactly 1 cycle with mem_we=1 and mem_addr=words_loaded*4, then increment words_loaded.
REQ-025 After WRITE, the FSM SHALL go to DONE if the new words_loaded==N, else back to DATA with the byte index reset to 0.
REQ-026 mem_we SHALL be high in exactly the cycle after the 4th byte is accepted; it SHALL be high at no other time.
REQ-027 Minimum throughput SHALL be 5 cycles per word; rx_valid gaps SHALL stall without losing state.
REQ-028 In DONE: cpu_hold=0 and done=1, held until start or rst.
REQ-029 In ERR: cpu_hold=1 and error=1, held until start or rst; no memory writes SHALL occur.
REQ-030 mem_addr SHALL never exceed (WORD_QUANTITY-1)*4.

Reset
REQ-031 On rst, the block SHALL enter IDLE with cpu_hold=1, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0 and words_loaded=0.
REQ-032 Reset mid-load SHALL discard any partial word and the captured N; no write SHALL be issued after rst asserts.
REQ-033 The CPU SHALL stay held after reset until a load reaches DONE.

Structure
REQ-034 A shared package SHALL hold the loader state enum typedef, WORD_QUANTITY default and BYTES_PER_WORD=4.
REQ-035 One sub-module, word_assembler, SHALL handle byte-index counting and little-endian packing; it SHALL have clear and load inputs and a word_full output.
REQ-036 The write port SHALL match the instruction-memory address scheme, where the word index is address[9:2] for 256 words.

Verification
REQ-037 Reset, start, bytes 02 00 93 00 00 00 13 01 10 00 -> writes 0x00000093 @0x0, then 0x00100113 @0x4; done=1, cpu_hold=0, words_loaded=2.
REQ-038 Header 01 01 (N=257) with WORD_QUANTITY=256 -> error=1, cpu_hold=1, no mem_we, rx_ready=0.
REQ-039 Header 00 00 -> done=1 two accepts after start; mem_we never asserted.
REQ-040 N=1 with rx_valid toggling every other cycle -> same write 1 cycle after the 4th accept; start pulsed mid-DATA is ignored.
REQ-041 rst asserted after 2 data bytes -> IDLE, outputs at reset values; a subsequent full N=1 load writes the correct word at 0x0.
REQ-042 N=256 load -> last write at mem_addr=0x3FC, words_loaded=256, then done=1.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package instr_mem_loader_pkg;

  localparam int unsigned WORD_QUANTITY_DEFAULT = 256;
  localparam int unsigned BYTES_PER_WORD        = 4;
  localparam int unsigned WORD_W                = BYTES_PER_WORD * 8;
  localparam int unsigned COUNT_W               = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs incoming bytes little-endian into one instruction word and tracks the byte index.
module word_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full,
  output logic              last_c
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;

  // The next accepted byte completes the word.
  assign last_c = (idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      word      <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      idx       <= '0;
      word      <= '0;
      word_full <= 1'b0;
    end else if (load) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + IDX_W'(1);
      word_full                <= last_c;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory while holding the CPU.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned WORD_QUANTITY = WORD_QUANTITY_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] words_loaded
);

  loader_state_t      state_q, state_d;
  logic [COUNT_W-1:0] n_q, n_d;
  logic [COUNT_W-1:0] words_d;
  logic [COUNT_W-1:0] n_hdr;
  logic [31:0]        mem_addr_d;
  logic               accept;
  logic               asm_clear;
  logic               asm_load;
  logic               word_full;
  logic               last_c;
  logic               rx_ready_d, mem_we_d, cpu_hold_d, done_d, error_d;

  assign accept = rx_valid && rx_ready;
  assign n_hdr  = {rx_data, n_q[7:0]};

  word_assembler u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .load      (asm_load),
    .byte_in   (rx_data),
    .word      (mem_wdata),
    .word_full (word_full),
    .last_c    (last_c)
  );

  // Next-state, header capture, word counting and registered-output values.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    words_d    = words_loaded;
    mem_addr_d = mem_addr;
    asm_clear  = 1'b0;
    asm_load   = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_LO;
          n_d        = '0;
          words_d    = '0;
          mem_addr_d = '0;
          asm_clear  = 1'b1;
        end
      end
      LEN_LO: begin
        if (accept) begin
          n_d[7:0] = rx_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          n_d       = n_hdr;
          asm_clear = 1'b1;
          if (n_hdr == '0) begin
            state_d = DONE;
          end else if (32'(n_hdr) > WORD_QUANTITY) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_load = 1'b1;
          if (last_c) begin
            state_d    = WRITE;
            mem_addr_d = 32'(words_loaded) << 2;
          end
        end
      end
      WRITE: begin
        asm_clear = 1'b1;
        state_d   = DATA;
        if (word_full) begin
          words_d = words_loaded + COUNT_W'(1);
          if (words_d == n_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
    mem_we_d   = (state_d == WRITE);
    cpu_hold_d = (state_d != DONE);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      words_loaded <= '0;
      mem_addr     <= '0;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      words_loaded <= words_d;
      mem_addr     <= mem_addr_d;
      rx_ready     <= rx_ready_d;
      mem_we       <= mem_we_d;
      cpu_hold     <= cpu_hold_d;
      done         <= done_d;
      error        <= error_d;
    end
  end

endmodule
